// File: rtl/outbox_uart_tx.sv
// Drains the CPU OUTBOX FIFO onto an 8N1 UART line, either as raw bytes or
// as an ASCII hex line ("HH\r\n") per popped word.
module outbox_uart_tx #(
    parameter int unsigned BAUD_DIV = 104,
    parameter int unsigned HEX_MODE = 0
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       empty,
    input  logic [7:0] data,
    output logic       rd,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(BAUD_DIV - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [1:0]  chr_q;
    logic [7:0]  hold_q;
    logic        rd_q;
    logic        tick;
    logic        last_chr;
    logic        capture;
    logic [7:0]  cur_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        return (nib < 4'd10) ? (8'h30 + wide) : (8'h37 + wide);
    endfunction

    assign tick     = (cnt_q == LAST_CNT);
    assign last_chr = (HEX_MODE == 0) || (chr_q == 2'd3);
    assign capture  = (state_q == IDLE) && !empty;

    // State register
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; STOP chains straight into START inside a hex line
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!empty) state_d = START;
            START: if (tick) state_d = DATA;
            DATA:  if (tick && (bit_q == 3'd7)) state_d = STOP;
            STOP:  if (tick) state_d = last_chr ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Bit timer, bit index, character index, holding register and pop strobe
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q  <= '0;
            bit_q  <= '0;
            chr_q  <= '0;
            hold_q <= '0;
            rd_q   <= 1'b0;
        end else begin
            rd_q <= capture;
            if (capture) begin
                hold_q <= data;
            end

            if ((state_q == IDLE) || tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end

            if (state_q != DATA) begin
                bit_q <= '0;
            end else if (tick) begin
                bit_q <= bit_q + 3'd1;
            end

            if (state_q == IDLE) begin
                chr_q <= '0;
            end else if ((state_q == STOP) && tick && (HEX_MODE != 0)) begin
                chr_q <= chr_q + 2'd1;
            end
        end
    end

    // Character currently on the wire
    always_comb begin
        cur_char = hold_q;
        if (HEX_MODE != 0) begin
            unique case (chr_q)
                2'd0: cur_char = hex_ascii(hold_q[7:4]);
                2'd1: cur_char = hex_ascii(hold_q[3:0]);
                2'd2: cur_char = 8'h0D;
                2'd3: cur_char = 8'h0A;
                default: cur_char = hold_q;
            endcase
        end
    end

    // Output decode
    always_comb begin
        tx   = 1'b1;
        busy = (state_q != IDLE);
        rd   = rd_q;
        unique case (state_q)
            IDLE:  tx = 1'b1;
            START: tx = 1'b0;
            DATA:  tx = cur_char[bit_q];
            STOP:  tx = 1'b1;
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_outbox_uart_tx.sv
// Directed bench for outbox_uart_tx: raw and hex framing, back-to-back pops,
// idle behaviour, mid-frame reset and input changes during a frame.
module tb_outbox_uart_tx;

    logic       clk;
    logic       i_rst;
    logic       empty0, empty1, empty2;
    logic [7:0] data0, data1, data2;
    logic       rd0, rd1, rd2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;

    int compared;
    int mismatched;

    logic txr [0:255];
    logic bsr [0:255];

    outbox_uart_tx #(.BAUD_DIV(4), .HEX_MODE(0)) dut0 (
        .clk(clk), .i_rst(i_rst), .empty(empty0), .data(data0),
        .rd(rd0), .tx(tx0), .busy(busy0)
    );

    outbox_uart_tx #(.BAUD_DIV(4), .HEX_MODE(1)) dut1 (
        .clk(clk), .i_rst(i_rst), .empty(empty1), .data(data1),
        .rd(rd1), .tx(tx1), .busy(busy1)
    );

    outbox_uart_tx #(.BAUD_DIV(2), .HEX_MODE(0)) dut2 (
        .clk(clk), .i_rst(i_rst), .empty(empty2), .data(data2),
        .rd(rd2), .tx(tx2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rebuild a byte from the recorded line, sampling mid-bit
    function automatic logic [7:0] decode(input int base, input int div);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = txr[base + div * (1 + i) + div / 2];
        end
        return b;
    endfunction

    task automatic test_reset();
        i_rst = 1'b0;
        #12;
        compared++;
        if ({tx0, tx1, tx2} !== 3'b111) begin
            mismatched++;
            $display("FAIL reset_tx: got %b expected 111", {tx0, tx1, tx2});
        end
        compared++;
        if ({rd0, rd1, rd2} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_rd: got %b expected 000", {rd0, rd1, rd2});
        end
        compared++;
        if ({busy0, busy1, busy2} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_busy: got %b expected 000", {busy0, busy1, busy2});
        end
        @(negedge clk);
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle();
        int bad_rd, bad_tx, bad_busy;
        bad_rd = 0; bad_tx = 0; bad_busy = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (rd0 !== 1'b0 || rd1 !== 1'b0) bad_rd++;
            if (tx0 !== 1'b1 || tx1 !== 1'b1) bad_tx++;
            if (busy0 !== 1'b0 || busy1 !== 1'b0) bad_busy++;
        end
        compared++;
        if (bad_rd != 0) begin mismatched++; $display("FAIL idle_rd: %0d cycles with rd high, expected 0", bad_rd); end
        compared++;
        if (bad_tx != 0) begin mismatched++; $display("FAIL idle_tx: %0d cycles with tx low, expected 0", bad_tx); end
        compared++;
        if (bad_busy != 0) begin mismatched++; $display("FAIL idle_busy: %0d cycles busy, expected 0", bad_busy); end
    endtask

    task automatic test_single();
        int w;
        logic [9:0] frame;
        logic exp_tx;
        frame = {1'b1, 8'hA5, 1'b0};
        data0 = 8'hA5;
        empty0 = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!rd0 && w < 20);
        empty0 = 1'b1;
        compared++;
        if (rd0 !== 1'b1 || w != 1) begin
            mismatched++;
            $display("FAIL single_rd_latency: rd=%b after %0d cycles, expected 1 after 1", rd0, w);
            return;
        end
        for (int k = 0; k < 45; k++) begin
            if (k > 0) @(negedge clk);
            exp_tx = (k < 40) ? frame[k / 4] : 1'b1;
            compared++;
            if (tx0 !== exp_tx) begin
                mismatched++;
                $display("FAIL single_tx[%0d]: got %b expected %b", k, tx0, exp_tx);
            end
            compared++;
            if (busy0 !== (k < 40)) begin
                mismatched++;
                $display("FAIL single_busy[%0d]: got %b expected %b", k, busy0, (k < 40));
            end
            compared++;
            if (rd0 !== (k == 0)) begin
                mismatched++;
                $display("FAIL single_rd[%0d]: got %b expected %b", k, rd0, (k == 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [0:2];
        int rdt [0:7];
        int nrd, idx;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        nrd = 0; idx = 0;
        data0 = bytes[0];
        empty0 = 1'b0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            txr[c] = tx0;
            if (rd0) begin
                if (nrd < 8) rdt[nrd] = c;
                nrd++;
                idx++;
                if (idx < 3) data0 = bytes[idx];
                else empty0 = 1'b1;
            end
        end
        compared++;
        if (nrd != 3) begin
            mismatched++;
            $display("FAIL b2b_pops: got %0d expected 3", nrd);
            return;
        end
        for (int p = 1; p < 3; p++) begin
            compared++;
            if (rdt[p] - rdt[p-1] != 41) begin
                mismatched++;
                $display("FAIL b2b_gap%0d: got %0d expected 41", p, rdt[p] - rdt[p-1]);
            end
        end
        for (int p = 0; p < 3; p++) begin
            compared++;
            if (decode(rdt[p], 4) !== bytes[p]) begin
                mismatched++;
                $display("FAIL b2b_byte%0d: got %h expected %h", p, decode(rdt[p], 4), bytes[p]);
            end
            compared++;
            if (txr[rdt[p] + 38] !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_stop%0d: got %b expected 1", p, txr[rdt[p] + 38]);
            end
        end
    endtask

    task automatic test_hex();
        int w, nrd, nbusy;
        logic [7:0] chars [0:3];
        chars[0] = 8'h33; chars[1] = 8'h46; chars[2] = 8'h0D; chars[3] = 8'h0A;
        data1 = 8'h3F;
        empty1 = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!rd1 && w < 20);
        empty1 = 1'b1;
        compared++;
        if (rd1 !== 1'b1) begin
            mismatched++;
            $display("FAIL hex_rd_timeout: rd=%b after %0d cycles, expected 1", rd1, w);
            return;
        end
        nrd = 1; nbusy = 0;
        txr[0] = tx1; bsr[0] = busy1;
        for (int k = 1; k < 170; k++) begin
            @(negedge clk);
            txr[k] = tx1; bsr[k] = busy1;
            if (rd1) nrd++;
        end
        for (int k = 0; k < 160; k++) if (bsr[k]) nbusy++;
        compared++;
        if (nrd != 1) begin mismatched++; $display("FAIL hex_pops: got %0d expected 1", nrd); end
        compared++;
        if (nbusy != 160) begin mismatched++; $display("FAIL hex_busy_len: got %0d expected 160", nbusy); end
        compared++;
        if (bsr[160] !== 1'b0) begin mismatched++; $display("FAIL hex_busy_end: got %b expected 0", bsr[160]); end
        for (int c = 0; c < 4; c++) begin
            compared++;
            if (txr[40 * c + 2] !== 1'b0) begin
                mismatched++;
                $display("FAIL hex_start%0d: got %b expected 0", c, txr[40 * c + 2]);
            end
            compared++;
            if (decode(40 * c, 4) !== chars[c]) begin
                mismatched++;
                $display("FAIL hex_char%0d: got %h expected %h", c, decode(40 * c, 4), chars[c]);
            end
            compared++;
            if (txr[40 * c + 38] !== 1'b1) begin
                mismatched++;
                $display("FAIL hex_stop%0d: got %b expected 1", c, txr[40 * c + 38]);
            end
        end
    endtask

    task automatic test_data_change();
        int w, nrd;
        int rdt [0:7];
        data2 = 8'hC3;
        empty2 = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!rd2 && w < 20);
        compared++;
        if (rd2 !== 1'b1) begin
            mismatched++;
            $display("FAIL chg_rd_timeout: rd=%b after %0d cycles, expected 1", rd2, w);
            empty2 = 1'b1;
            return;
        end
        txr[0] = tx2;
        nrd = 1; rdt[0] = 0;
        for (int k = 1; k < 43; k++) begin
            if (k < 20) begin
                data2 = 8'(k * 37);
                empty2 = ((k % 2) == 1);
            end else if (k == 20) begin
                data2 = 8'h5A;
                empty2 = 1'b0;
            end
            @(negedge clk);
            txr[k] = tx2;
            if (rd2) begin
                if (nrd < 8) rdt[nrd] = k;
                nrd++;
            end
            if (k >= 21) empty2 = 1'b1;
        end
        compared++;
        if (nrd != 2) begin
            mismatched++;
            $display("FAIL chg_pops: got %0d expected 2", nrd);
            return;
        end
        compared++;
        if (rdt[1] != 21) begin mismatched++; $display("FAIL chg_second_rd: got cycle %0d expected 21", rdt[1]); end
        compared++;
        if (decode(0, 2) !== 8'hC3) begin mismatched++; $display("FAIL chg_byte0: got %h expected c3", decode(0, 2)); end
        compared++;
        if (decode(21, 2) !== 8'h5A) begin mismatched++; $display("FAIL chg_byte1: got %h expected 5a", decode(21, 2)); end
        compared++;
        if (txr[19] !== 1'b1) begin mismatched++; $display("FAIL chg_stop0: got %b expected 1", txr[19]); end
    endtask

    task automatic test_reset_mid();
        int w, bad;
        data0 = 8'h55;
        empty0 = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!rd0 && w < 20);
        empty0 = 1'b1;
        compared++;
        if (rd0 !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_rd_timeout: rd=%b after %0d cycles, expected 1", rd0, w);
            return;
        end
        repeat (17) @(negedge clk);
        compared++;
        if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_bit3: tx=%b busy=%b expected tx=0 busy=1", tx0, busy0);
        end
        i_rst = 1'b0;
        #1;
        compared++;
        if (tx0 !== 1'b1) begin mismatched++; $display("FAIL rstmid_tx: got %b expected 1", tx0); end
        compared++;
        if (busy0 !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %b expected 0", busy0); end
        @(negedge clk);
        i_rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rd0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        compared++;
        if (bad != 0) begin mismatched++; $display("FAIL rstmid_after: %0d active cycles, expected 0", bad); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        i_rst = 1'b0;
        empty0 = 1'b1; empty1 = 1'b1; empty2 = 1'b1;
        data0 = '0; data1 = '0; data2 = '0;
        test_reset();
        test_idle();
        test_single();
        repeat (5) @(negedge clk);
        test_back_to_back();
        repeat (5) @(negedge clk);
        test_hex();
        repeat (5) @(negedge clk);
        test_data_change();
        repeat (30) @(negedge clk);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
